// File: rtl/ahb_arb_pkg.sv
// Shared AHB encodings, beat-counter width and burst-length helper for the bus arbiter.
package ahb_arb_pkg;

  localparam int unsigned BEAT_CNT_W = 4;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'd0,
    HRESP_ERROR = 2'd1,
    HRESP_RETRY = 2'd2,
    HRESP_SPLIT = 2'd3
  } hresp_e;

  // Muxed control of the bus-owning master as seen by the arbiter.
  typedef struct packed {
    logic [1:0] htrans;
    logic [2:0] hburst;
    logic       hready;
    logic [1:0] hresp;
  } ahb_ctrl_t;

  // Remaining beats after the first address phase of a burst.
  function automatic logic [BEAT_CNT_W-1:0] burst_beats(input logic [2:0] hburst);
    case (hburst)
      HBURST_INCR4,  HBURST_WRAP4:  burst_beats = BEAT_CNT_W'(3);
      HBURST_INCR8,  HBURST_WRAP8:  burst_beats = BEAT_CNT_W'(7);
      HBURST_INCR16, HBURST_WRAP16: burst_beats = BEAT_CNT_W'(15);
      default:                      burst_beats = '0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_arb_rr_pick.sv
// Combinational rotating-priority picker: first eligible requester after ptr_i, with wrap.
module ahb_arb_rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [N-1:0]  mask_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  winner_c_o,
  output logic          valid_c_o
);

  logic [N-1:0]  eligible;
  logic [N-1:0]  winner;
  logic [IW-1:0] idx;
  logic          found;

  // Scan offsets 1..N so the last winner has lowest priority but can still win alone.
  always_comb begin
    eligible = req_i & ~mask_i;
    winner   = '0;
    found    = 1'b0;
    idx      = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = IW'((32'(ptr_i) + k) % N);
      if (!found && eligible[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
    winner_c_o = winner;
    valid_c_o  = found;
  end

endmodule

// File: rtl/ahb_bus_arbiter_hdl.sv
// Round-robin AHB arbiter honouring fixed-length bursts and locked transfers.
// Optional split support (HSPLIT port, split mask) is built when AHB_ARB_SPLIT_EN is defined.
module ahb_bus_arbiter_hdl
  import ahb_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS     = 4,
  parameter int unsigned NUM_MASTER_BITS = 2,
  parameter int unsigned DEFAULT_MASTER  = 0
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,
  input  logic [NUM_MASTERS-1:0]     HBUSREQ,
  input  logic [NUM_MASTERS-1:0]     HLOCK,
  input  logic [1:0]                 HTRANS,
  input  logic [2:0]                 HBURST,
  input  logic                       HREADY,
  input  logic [1:0]                 HRESP,
`ifdef AHB_ARB_SPLIT_EN
  input  logic [NUM_MASTERS-1:0]     HSPLIT,
`endif
  output logic [NUM_MASTERS-1:0]     HGRANT,
  output logic [NUM_MASTER_BITS-1:0] HMASTER,
  output logic                       HMASTLOCK
);

  localparam int unsigned                CW        = BEAT_CNT_W;
  localparam logic [NUM_MASTERS-1:0]     DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;
  localparam logic [NUM_MASTER_BITS-1:0] DEF_IDX   = NUM_MASTER_BITS'(DEFAULT_MASTER);

  ahb_ctrl_t                  bus_ctrl;
  logic [NUM_MASTERS-1:0]     grant_q, grant_d;
  logic [NUM_MASTER_BITS-1:0] master_q, master_d;
  logic                       mastlock_q, mastlock_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [NUM_MASTER_BITS-1:0] last_q, last_d;
  logic [NUM_MASTER_BITS-1:0] grant_idx;
  logic [NUM_MASTER_BITS-1:0] winner_idx;
  logic [NUM_MASTERS-1:0]     split_mask;
  logic [NUM_MASTERS-1:0]     winner_c;
  logic                       winner_vld_c;
  logic                       resp_abort;
  logic                       arb_ok;

  assign bus_ctrl = '{htrans: HTRANS, hburst: HBURST, hready: HREADY, hresp: HRESP};

  ahb_arb_rr_pick #(
    .N  (NUM_MASTERS),
    .IW (NUM_MASTER_BITS)
  ) u_rr_pick (
    .req_i      (HBUSREQ),
    .mask_i     (split_mask),
    .ptr_i      (last_q),
    .winner_c_o (winner_c),
    .valid_c_o  (winner_vld_c)
  );

  // One-hot to index for the current grant and the picker's winner.
  always_comb begin
    grant_idx  = '0;
    winner_idx = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[i])  grant_idx  = NUM_MASTER_BITS'(i);
      if (winner_c[i]) winner_idx = NUM_MASTER_BITS'(i);
    end
  end

  // Second cycle of an ERROR/RETRY/SPLIT response: burst is abandoned.
  always_comb begin
    resp_abort = bus_ctrl.hready && (bus_ctrl.hresp != HRESP_OKAY);
    arb_ok = (cnt_q == '0)
          || ((cnt_q == CW'(1)) && (bus_ctrl.htrans == HTRANS_SEQ) && bus_ctrl.hready)
          || (bus_ctrl.htrans == HTRANS_IDLE)
          || (bus_ctrl.htrans == HTRANS_NONSEQ)
          || (bus_ctrl.hburst == HBURST_INCR)
          || resp_abort;
    if (HLOCK[grant_idx]) arb_ok = 1'b0;
  end

  // Beat counter, grant and ownership only move on ready cycles.
  always_comb begin
    cnt_d      = cnt_q;
    grant_d    = grant_q;
    last_d     = last_q;
    master_d   = master_q;
    mastlock_d = mastlock_q;
    if (bus_ctrl.hready) begin
      if (resp_abort) begin
        cnt_d = '0;
      end else begin
        case (bus_ctrl.htrans)
          HTRANS_NONSEQ: cnt_d = burst_beats(bus_ctrl.hburst);
          HTRANS_SEQ:    if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
          HTRANS_IDLE:   cnt_d = '0;
          default:       cnt_d = cnt_q;
        endcase
      end
      if (arb_ok) begin
        if (winner_vld_c) begin
          grant_d = winner_c;
          last_d  = winner_idx;
        end else begin
          grant_d = DEF_GRANT;
        end
      end
      master_d   = grant_idx;
      mastlock_d = HLOCK[grant_idx];
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      grant_q    <= DEF_GRANT;
      master_q   <= DEF_IDX;
      mastlock_q <= 1'b0;
      cnt_q      <= '0;
      last_q     <= DEF_IDX;
    end else begin
      grant_q    <= grant_d;
      master_q   <= master_d;
      mastlock_q <= mastlock_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
    end
  end

`ifdef AHB_ARB_SPLIT_EN
  logic [NUM_MASTERS-1:0] mask_q, mask_d;

  // First SPLIT response cycle parks the owner; HSPLIT release wins over a same-cycle set.
  always_comb begin
    mask_d = mask_q;
    if (!bus_ctrl.hready && (bus_ctrl.hresp == HRESP_SPLIT)) mask_d[master_q] = 1'b1;
    mask_d = mask_d & ~HSPLIT;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) mask_q <= '0;
    else          mask_q <= mask_d;
  end

  assign split_mask = mask_q;
`else
  assign split_mask = '0;
`endif

  assign HGRANT    = grant_q;
  assign HMASTER   = master_q;
  assign HMASTLOCK = mastlock_q;

endmodule

// File: tb/tb_ahb_bus_arbiter_hdl.sv
// Directed plus randomized bench for ahb_bus_arbiter_hdl against a behavioural arbitration model.
module tb_ahb_bus_arbiter_hdl;

  logic       HCLK;
  logic       HRESETn;
  logic [3:0] HBUSREQ;
  logic [3:0] HLOCK;
  logic [1:0] HTRANS;
  logic [2:0] HBURST;
  logic       HREADY;
  logic [1:0] HRESP;
`ifdef AHB_ARB_SPLIT_EN
  logic [3:0] HSPLIT;
`endif
  logic [3:0] HGRANT;
  logic [1:0] HMASTER;
  logic       HMASTLOCK;

  ahb_bus_arbiter_hdl #(
    .NUM_MASTERS     (4),
    .NUM_MASTER_BITS (2),
    .DEFAULT_MASTER  (0)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HBUSREQ   (HBUSREQ),
    .HLOCK     (HLOCK),
    .HTRANS    (HTRANS),
    .HBURST    (HBURST),
    .HREADY    (HREADY),
    .HRESP     (HRESP),
`ifdef AHB_ARB_SPLIT_EN
    .HSPLIT    (HSPLIT),
`endif
    .HGRANT    (HGRANT),
    .HMASTER   (HMASTER),
    .HMASTLOCK (HMASTLOCK)
  );

  int n_vec;
  int n_err;

  // Model state: who holds the grant, who owns the bus, beats left, last winner, parked masters.
  logic [1:0] m_grant;
  logic [1:0] m_master;
  logic       m_lock;
  int         m_cnt;
  logic [1:0] m_last;
  logic [3:0] m_mask;
  int         beats_tbl [8] = '{0, 0, 3, 3, 7, 7, 15, 15};

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_grant  = 2'd0;
    m_master = 2'd0;
    m_lock   = 1'b0;
    m_cnt    = 0;
    m_last   = 2'd0;
    m_mask   = 4'd0;
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    HBUSREQ = 4'd0; HLOCK = 4'd0; HTRANS = 2'd0; HBURST = 3'd0; HREADY = 1'b1; HRESP = 2'd0;
`ifdef AHB_ARB_SPLIT_EN
    HSPLIT = 4'd0;
`endif
    #2;
    check("rst_async_grant", 32'(HGRANT), 32'h1);
    check("rst_async_master", 32'(HMASTER), 32'h0);
    check("rst_async_lock", 32'(HMASTLOCK), 32'h0);
    @(posedge HCLK); #1;
    check("rst_hold_grant", 32'(HGRANT), 32'h1);
    @(negedge HCLK);
    HRESETn = 1'b1;
    model_reset();
  endtask

  // Apply one cycle of bus inputs, advance the model by the arbitration rules, then compare.
  task automatic step(input logic [3:0] req, input logic [3:0] lk, input logic [1:0] tr,
                      input logic [2:0] bu, input logic rdy, input logic [1:0] rs,
                      input logic [3:0] sp);
    logic [1:0] n_grant, n_last, n_master, cand;
    logic       n_lock, ok, found;
    int         n_cnt;
    logic [3:0] n_mask;
    HBUSREQ = req; HLOCK = lk; HTRANS = tr; HBURST = bu; HREADY = rdy; HRESP = rs;
`ifdef AHB_ARB_SPLIT_EN
    HSPLIT = sp;
`endif
    n_grant = m_grant; n_last = m_last; n_master = m_master;
    n_lock = m_lock; n_cnt = m_cnt; n_mask = m_mask;
    if (rdy) begin
      ok = (m_cnt == 0) || (m_cnt == 1 && tr == 2'd3) || (tr == 2'd0) || (tr == 2'd2)
        || (bu == 3'd1) || (rs != 2'd0);
      if (lk[m_grant]) ok = 1'b0;
      if (rs != 2'd0) n_cnt = 0;
      else if (tr == 2'd0) n_cnt = 0;
      else if (tr == 2'd2) n_cnt = beats_tbl[bu];
      else if (tr == 2'd3) n_cnt = (m_cnt > 0) ? m_cnt - 1 : 0;
      if (ok) begin
        found   = 1'b0;
        n_grant = 2'd0;
        for (int k = 1; k <= 4; k++) begin
          cand = m_last + 2'(k);
          if (!found && req[cand] && !m_mask[cand]) begin
            found   = 1'b1;
            n_grant = cand;
            n_last  = cand;
          end
        end
      end
      n_master = m_grant;
      n_lock   = lk[m_grant];
    end
`ifdef AHB_ARB_SPLIT_EN
    if (!rdy && rs == 2'd3) n_mask[m_master] = 1'b1;
    n_mask = n_mask & ~sp;
`endif
    @(posedge HCLK); #1;
    m_grant = n_grant; m_last = n_last; m_master = n_master;
    m_lock = n_lock; m_cnt = n_cnt; m_mask = n_mask;
    check("HGRANT", 32'(HGRANT), 32'(4'b0001 << m_grant));
    check("HMASTER", 32'(HMASTER), 32'(m_master));
    check("HMASTLOCK", 32'(HMASTLOCK), 32'(m_lock));
  endtask

  initial begin
    logic [3:0] r_req, r_lk, r_sp;
    logic [1:0] r_rs;
    logic       saw2;
    n_vec = 0;
    n_err = 0;
    HRESETn = 1'b1;
    model_reset();
    #1;
    do_reset();

    // Idle bus parks on the default master.
    for (int i = 0; i < 10; i++) step(4'd0, 4'd0, 2'd0, 3'd0, 1'b1, 2'd0, 4'd0);
    check("idle_grant", 32'(HGRANT), 32'h1);

    // SINGLE transfers from masters 1..3 rotate one per cycle.
    step(4'b1110, 4'd0, 2'd2, 3'd0, 1'b1, 2'd0, 4'd0);
    check("rr_first", 32'(HGRANT), 32'h2);
    for (int i = 0; i < 7; i++) step(4'b1110, 4'd0, 2'd2, 3'd0, 1'b1, 2'd0, 4'd0);

    // INCR8 by master 1; master 2 waits for the final beat.
    step(4'b0010, 4'd0, 2'd0, 3'd0, 1'b1, 2'd0, 4'd0);
    step(4'b0010, 4'd0, 2'd2, 3'd5, 1'b1, 2'd0, 4'd0);
    for (int i = 0; i < 6; i++) step(4'b0110, 4'd0, 2'd3, 3'd5, 1'b1, 2'd0, 4'd0);
    check("incr8_hold", 32'(HGRANT), 32'h2);
    step(4'b0110, 4'd0, 2'd3, 3'd5, 1'b1, 2'd0, 4'd0);
    check("incr8_handover", 32'(HGRANT), 32'h4);
    check("incr8_owner", 32'(HMASTER), 32'h1);

    // Locked INCR bursts by master 3.
    step(4'b1000, 4'b1000, 2'd0, 3'd1, 1'b1, 2'd0, 4'd0);
    step(4'b1111, 4'b1000, 2'd2, 3'd1, 1'b1, 2'd0, 4'd0);
    for (int i = 0; i < 5; i++) step(4'b1111, 4'b1000, 2'd3, 3'd1, 1'b1, 2'd0, 4'd0);
    check("lock_grant", 32'(HGRANT), 32'h8);
    check("lock_mastlock", 32'(HMASTLOCK), 32'h1);
    step(4'b1111, 4'd0, 2'd3, 3'd1, 1'b1, 2'd0, 4'd0);
    check("unlock_grant", 32'(HGRANT), 32'h1);

    // WRAP4 by master 1 with three wait states.
    step(4'b0010, 4'd0, 2'd0, 3'd0, 1'b1, 2'd0, 4'd0);
    step(4'b0010, 4'd0, 2'd2, 3'd2, 1'b1, 2'd0, 4'd0);
    step(4'b0011, 4'd0, 2'd3, 3'd2, 1'b1, 2'd0, 4'd0);
    for (int i = 0; i < 3; i++) step(4'b0011, 4'd0, 2'd3, 3'd2, 1'b0, 2'd0, 4'd0);
    check("wait_grant", 32'(HGRANT), 32'h2);
    check("wait_master", 32'(HMASTER), 32'h1);
    step(4'b0011, 4'd0, 2'd3, 3'd2, 1'b1, 2'd0, 4'd0);
    check("wrap4_beat3", 32'(HGRANT), 32'h2);
    step(4'b0011, 4'd0, 2'd3, 3'd2, 1'b1, 2'd0, 4'd0);
    check("wrap4_done", 32'(HGRANT), 32'h1);

    // Reset in the middle of an INCR16 leaves no burst protection behind.
    step(4'b0001, 4'd0, 2'd2, 3'd7, 1'b1, 2'd0, 4'd0);
    step(4'b0011, 4'd0, 2'd3, 3'd7, 1'b1, 2'd0, 4'd0);
    do_reset();
    step(4'b0010, 4'd0, 2'd3, 3'd7, 1'b1, 2'd0, 4'd0);
    check("post_reset_arb", 32'(HGRANT), 32'h2);

`ifdef AHB_ARB_SPLIT_EN
    // SPLIT parks master 2 until HSPLIT[2] releases it.
    step(4'b0100, 4'd0, 2'd0, 3'd0, 1'b1, 2'd0, 4'd0);
    step(4'b0100, 4'd0, 2'd0, 3'd0, 1'b1, 2'd0, 4'd0);
    step(4'b0100, 4'd0, 2'd2, 3'd0, 1'b0, 2'd3, 4'd0);
    step(4'b0111, 4'd0, 2'd0, 3'd0, 1'b1, 2'd3, 4'd0);
    saw2 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(4'b0111, 4'd0, 2'd0, 3'd0, 1'b1, 2'd0, 4'd0);
      saw2 = saw2 | HGRANT[2];
    end
    check("split_masked", 32'(saw2), 32'h0);
    step(4'b0111, 4'd0, 2'd0, 3'd0, 1'b1, 2'd0, 4'b0100);
    saw2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(4'b0111, 4'd0, 2'd0, 3'd0, 1'b1, 2'd0, 4'd0);
      saw2 = saw2 | HGRANT[2];
    end
    check("split_regrant", 32'(saw2), 32'h1);
`endif

    // Random traffic against the model, with one reset part-way through.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      r_req = 4'($urandom);
      r_lk  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'd0;
      r_rs  = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'd0;
      r_sp  = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'd0;
      step(r_req, r_lk, 2'($urandom), 3'($urandom), ($urandom_range(0, 3) != 0), r_rs, r_sp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ahb_bus_arbiter_hdl.md
Name: ahb_bus_arbiter_hdl

Overview:
- Round-robin AHB bus arbiter that shares one AHB bus among NUM_MASTERS masters feeding the memory slave and other slaves.
- Generates HGRANT, HMASTER and HMASTLOCK.
- Honours fixed-length burst boundaries and locked transfers.
- Sits beside the decoder in the HDL-side bus top and drives the arbiter_* signals consumed by slaves and monitors.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..16).
- NUM_MASTER_BITS, 2, width of HMASTER; must satisfy 2**NUM_MASTER_BITS >= NUM_MASTERS.
- DEFAULT_MASTER, 0, master granted when nobody requests.

Ports:
- HCLK  input  1  bus clock; all state changes on its rising edge.
- HRESETn  input  1  asynchronous active-low reset.
- HBUSREQ  input  NUM_MASTERS  per-master bus request.
- HLOCK  input  NUM_MASTERS  per-master locked-transfer request.
- HTRANS  input  2  muxed HTRANS of the bus-owning master (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
- HBURST  input  3  muxed HBURST.
- HREADY  input  1  muxed bus ready.
- HRESP  input  2  muxed slave response (OKAY=0, ERROR=1, RETRY=2, SPLIT=3).
- HGRANT  output  NUM_MASTERS  one-hot grant.
- HMASTER  output  NUM_MASTER_BITS  index of the address-phase owner.
- HMASTLOCK  output  1  current address phase is locked.

Behaviour:
- Reset (async, HRESETn=0):
  - HGRANT = one-hot(DEFAULT_MASTER), HMASTER = DEFAULT_MASTER, HMASTLOCK = 0.
  - Beat counter = 0; round-robin pointer = DEFAULT_MASTER.
- Release: outputs leave reset values no earlier than the first HCLK edge after HRESETn rises.
- HGRANT is always exactly one-hot.
- Beat counter (width 4):
  - On HREADY=1 with HTRANS=NONSEQ, load burst length minus 1: INCR4/WRAP4 -> 3, INCR8/WRAP8 -> 7, INCR16/WRAP16 -> 15, SINGLE/INCR -> 0.
  - On HREADY=1 with HTRANS=SEQ and counter > 0, decrement.
  - BUSY holds the counter; IDLE clears it.
- arb_ok is true when any of:
  - counter == 0;
  - counter == 1 with HTRANS=SEQ and HREADY=1 (re-grant one address phase before the final beat);
  - HTRANS=IDLE;
  - HBURST=INCR (undefined length, arbitrable every beat);
  - HRESP is RETRY, SPLIT or ERROR (second response cycle, HREADY=1); this also clears the counter.
- Lock: if HLOCK[granted] is 1, arb_ok is forced false.
- Grant update, at an HCLK edge with HREADY=1 and arb_ok:
  - Pick the first requesting master scanning from (last_granted+1) mod NUM_MASTERS upward with wrap.
  - If none is requesting, grant DEFAULT_MASTER.
  - The current owner still requesting with no others requesting keeps the grant.
  - last_granted is updated only when a requesting master wins.
- HREADY=0: HGRANT, HMASTER, HMASTLOCK and the counter are all frozen.
- At an HCLK edge with HREADY=1: HMASTER <= index(HGRANT) and HMASTLOCK <= HLOCK[index(HGRANT)]. Ownership therefore follows the grant by one ready cycle.
- Latency: request to HGRANT is 1 cycle when arb_ok; HGRANT to HMASTER is 1 HREADY cycle.
- Early termination: NONSEQ or IDLE seen while counter > 0 reloads or clears the counter per the counter rules; arbitration is then permitted that cycle.
- Simultaneous requests: resolved purely by the rotating priority. A burst already in progress finishes first unless the counter is cleared by an ERROR/RETRY/SPLIT response or by early termination.
- Reset mid-burst: everything returns to reset values immediately; no partial state survives.

Optional Feature:
- Macro: AHB_ARB_SPLIT_EN.
- With the macro defined:
  - Extra input port HSPLIT (NUM_MASTERS).
  - Per-master split mask register, reset 0.
  - When HRESP=SPLIT and HREADY=0 (first response cycle), mask bit [HMASTER] is set.
  - HSPLIT[i]=1 clears mask bit i on the next edge; if set and clear happen in the same cycle, clear wins.
  - Masked masters are excluded from arbitration.
  - If all requesters are masked, grant DEFAULT_MASTER.
- Without the macro: no HSPLIT port, no mask; SPLIT is treated exactly like RETRY.

Decomposition:
- Package ahb_arb_pkg holds:
  - HTRANS, HBURST and HRESP enums/constants;
  - function burst_beats(hburst) returning the count-minus-1;
  - localparam for the counter width.
- One combinational sub-module, ahb_arb_rr_pick: inputs are the request vector, mask and pointer; output is the one-hot winner and a valid flag.

Test Plan:
1. Reset with NUM_MASTERS=4 and no requests -> HGRANT=4'b0001, HMASTER=0, HMASTLOCK=0; state unchanged after 10 idle cycles.
2. HBUSREQ=4'b1110 held, masters issue SINGLE transfers, HREADY=1 -> grants rotate 1,2,3,1,... one per cycle; HMASTER lags HGRANT by 1 cycle.
3. Master 1 performs an INCR8 burst while master 2 requests -> HGRANT moves to master 2 only on the edge where the counter goes 1->0 (8th address phase); never earlier.
4. Master 3 holds HLOCK=1 with INCR bursts while masters 0..2 request -> HGRANT stays 4'b1000 and HMASTLOCK=1 until HLOCK drops, then the grant passes to master 0.
5. Insert 3 HREADY=0 wait states mid-WRAP4 -> HGRANT, HMASTER and the counter are frozen during the waits; arbitration resumes after the final beat.
6. With AHB_ARB_SPLIT_EN: SPLIT to master 2 -> master 2 is excluded from grants; pulse HSPLIT[2] -> master 2 is granted on its next round-robin turn.
